uart_rx_fifo: RTL

Synthesizable UART receiver that consumes the serial line driven by the SoC's UART transmitter (uart_tx_pin), or by an external host on a loopback or RX pin. It deserializes 8N1 frames and buffers completed bytes in a small FIFO. The FIFO feeds a valid/ready consumer, normally the CPU peripheral register bank. It is timed from the same CLOCK_HZ/BAUD pair used by the transmitter.

---
 rtl/uart_rx_fifo.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small byte FIFO.
// Ports: clk; reset (sync, active high); rx_pin (async serial in, idle high);
//   rx_data/rx_valid/rx_ready (FIFO head with valid/ready pop);
//   overrun/framing_error (sticky, cleared by err_clear); fill (occupancy).
// Define UART_RX_PARITY_EN for an even parity bit and a parity_error output.
module uart_rx_fifo #(
    parameter int CLOCK_HZ   = 20_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_pin,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          overrun,
    output logic                          framing_error,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_error,
`endif
    input  logic                          err_clear,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);
    localparam int DIV  = CLOCK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int FW   = AW + 1;
    localparam int CW   = $clog2(DIV + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    logic          rx_meta;
    logic          rx_s;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          expired;
    logic          push;
    logic          fe_set;
`ifdef UART_RX_PARITY_EN
    logic          par_bad;
    logic          pe_set;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_pin;
            rx_s    <= rx_meta;
        end
    end

    assign expired = (cnt == '0);

    // Frame-complete strobes, decoded in the stop-sample cycle so the
    // FIFO write lands on the same edge as the stop-bit sample.
    always_comb begin
        push   = 1'b0;
        fe_set = 1'b0;
        if (state == STOP && expired) begin
`ifdef UART_RX_PARITY_EN
            push = rx_s && !par_bad;
`else
            push = rx_s;
`endif
            fe_set = !rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign pe_set = (state == PARITY) && expired && (^{shreg, rx_s});
`endif

    // Loading N makes the sample fall N+1 edges later, hence the -1s.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            if (!expired) cnt <= cnt - CW'(1);
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= CW'(HALF - 1);
                    end
                end
                START: begin
                    if (expired) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            cnt     <= CW'(DIV - 1);
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (expired) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        cnt     <= CW'(DIV - 1);
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (expired) begin
                        par_bad <= ^{shreg, rx_s};
                        cnt     <= CW'(DIV - 1);
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (expired) state <= rx_s ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    assign rx_valid = (fill != '0);
    assign rx_data  = mem[rd_ptr];
    assign full     = (fill == FW'(FIFO_DEPTH));
    assign do_pop   = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && full && !do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop) fill <= fill + FW'(1);
            else if (!do_push && do_pop) fill <= fill - FW'(1);
        end
    end

    // Set has priority over err_clear so no event is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun       <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
        end else begin
            if (drop) overrun <= 1'b1;
            else if (err_clear) overrun <= 1'b0;
            if (fe_set) framing_error <= 1'b1;
            else if (err_clear) framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (pe_set) parity_error <= 1'b1;
            else if (err_clear) parity_error <= 1'b0;
`endif
        end
    end

endmodule
